hbridge_drv: RTL
================

HBRIDGE_DRV -- requirements
Module: hbridge_drv

Interface
REQ-001 Parameter: DEAD_TIME, default 16, gate-off interval in clk cycles; legal range 1..255; 8-bit counter.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: en  input  1  drive enable; 0 = coast, all gates off.
REQ-005 Port: PWM_sig  input  1  duty waveform from the upstream 8-bit PWM generator.
REQ-006 Port: dir  input  1  0 = leg A switches and leg B is held low; 1 = leg B switches and leg A is held low.
REQ-007 Port: brake  input  1  request for both low-side gates on.
REQ-008 Port: ah, al, bh, bl  output  1 each  H-bridge gate drives (A/B leg, high/low side); registered.
REQ-009 Port: busy  output  1  high while any dead-time interval is running; registered.

Function
REQ-010 States SHALL be IDLE, DT_ALL, DT_LEG, LO, HI, BRAKE, with the following outputs (active leg = dir_lat):
- IDLE and DT_ALL: all gates 0.
- DT_LEG: active leg off; inactive low = 1.
- LO: active low = 1; inactive low = 1.
- HI: active high = 1; inactive low = 1.
- BRAKE: al = bl = 1.
REQ-011 Transition priority SHALL be: rst, then !en, then brake, then dir change, then PWM_sig.
REQ-012 Any state with en=0 SHALL go to IDLE on the next edge.
REQ-013 IDLE with en=1 SHALL latch dir_lat = dir, load the counter and enter DT_ALL.
REQ-014 DT_ALL and DT_LEG SHALL each last exactly DEAD_TIME cycles, then exit:
- DT_ALL exits to BRAKE if brake=1, else to LO.
- DT_LEG exits to HI if PWM_sig=1 at the exit edge, else to LO.
REQ-015 LO transitions:
- brake=1: go directly to BRAKE.
- dir != dir_lat: latch dir and enter DT_ALL.
- PWM_sig=1: enter DT_LEG.
REQ-016 HI transitions:
- brake=1, or dir != dir_lat: latch dir and enter DT_ALL.
- PWM_sig=0: enter DT_LEG.
REQ-017 In DT_LEG, brake=1 or a dir change SHALL restart the interval in DT_ALL (dir latched).
REQ-018 BRAKE with brake=0 SHALL latch dir and enter LO.
REQ-019 Gate timing:
- Latency from the sampling edge to the gate change SHALL be one edge.
- The PWM_sig rise to active-high rise delay SHALL be DEAD_TIME+1 cycles.
- The active-low fall SHALL occur 1 cycle after PWM_sig rises.
REQ-020 A leg's high and low gates SHALL never both be 1 in any cycle.
REQ-021 A high gate SHALL never turn on fewer than DEAD_TIME cycles after the same leg's low gate turns off, and vice versa.
REQ-022 A PWM_sig pulse shorter than DEAD_TIME SHALL be absorbed without asserting any high gate.
REQ-023 busy SHALL equal 1 exactly in DT_ALL and DT_LEG.

Reset
REQ-024 rst=1 SHALL force, at the next edge:
- state = IDLE;
- ah = al = bh = bl = 0;
- busy = 0;
- dir_lat = 0;
- counter = 0.
REQ-025 Reset asserted mid-interval or in HI SHALL take effect at the next edge; no pending transition survives.

Configuration
REQ-026 Macro HBRIDGE_BRAKE_EN defined: BRAKE state and brake behaviour present, as specified above.
REQ-027 Macro HBRIDGE_BRAKE_EN undefined:
- BRAKE state is removed.
- The brake port remains but is ignored.
- DT_ALL always exits to LO.

Structure
REQ-028 Shared package motor_pkg SHALL hold:
- the state enumeration;
- the DEAD_TIME default constant;
- the counter width constant (8).
REQ-029 Sub-module dt_timer SHALL be the single sub-module: 8-bit down counter with load, and an expire pulse on the final interval cycle.

Verification
REQ-030 DEAD_TIME=16; rst high, then en=1, dir=0 -> DT_ALL for 16 cycles with all gates 0, then al=bl=1; busy high for exactly 16 cycles.
REQ-031 In LO, PWM_sig rises -> al=0 next cycle, ah=1 after 16 more cycles; PWM_sig falls -> ah=0 next cycle, al=1 16 cycles later; bl stays 1 throughout.
REQ-032 In HI, PWM_sig low pulse of 5 cycles -> ah=0, DT_LEG lasts 16 cycles, then ah=1; al stays 0; no cycle with ah&al.
REQ-033 In HI, dir toggles to 1 -> all gates 0 for 16 cycles, then bl=al=1 (LO with leg B active).
REQ-034 With HBRIDGE_BRAKE_EN: brake=1 in HI -> 16 cycles with all gates 0, then al=bl=1; brake=0 -> LO next edge. Without the macro, brake has no effect.
REQ-035 rst=1 asserted during DT_LEG at cycle 7 -> all outputs 0 and busy=0 next edge; the continuous bench assertion for REQ-020 never fires.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constants for the H-bridge gate driver.
// HBRIDGE_BRAKE_EN adds the BRAKE state (both low-side gates on).
package motor_pkg;

  localparam int unsigned DeadTimeDefault = 16;
  localparam int unsigned CntW            = 8;

  typedef enum logic [2:0] {
    StIdle,
    StDtAll,
    StDtLeg,
    StLo,
`ifdef HBRIDGE_BRAKE_EN
    StHi,
    StBrake
`else
    StHi
`endif
  } state_e;

  typedef struct packed {
    logic ah;
    logic al;
    logic bh;
    logic bl;
  } gates_t;

  // leg_b selects leg B as the switching leg; the other leg's low side is held on.
  function automatic gates_t gate_decode(state_e st, logic leg_b);
    gates_t g;
    g = '0;
    case (st)
      StDtLeg: begin
        if (leg_b) g.al = 1'b1;
        else       g.bl = 1'b1;
      end
      StLo: begin
        g.al = 1'b1;
        g.bl = 1'b1;
      end
      StHi: begin
        if (leg_b) begin
          g.bh = 1'b1;
          g.al = 1'b1;
        end else begin
          g.ah = 1'b1;
          g.bl = 1'b1;
        end
      end
`ifdef HBRIDGE_BRAKE_EN
      StBrake: begin
        g.al = 1'b1;
        g.bl = 1'b1;
      end
`endif
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/dt_timer.sv
// Dead-time down counter: load starts an interval, expire_o marks its final cycle.
module dt_timer
  import motor_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic            expire_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/hbridge_drv.sv
// H-bridge gate driver with dead-time insertion and registered gate outputs.
// Build with HBRIDGE_BRAKE_EN defined to enable the low-side brake state.
module hbridge_drv
  import motor_pkg::*;
#(
  parameter int unsigned DEAD_TIME = DeadTimeDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic PWM_sig,
  input  logic dir,
  input  logic brake,
  output logic ah,
  output logic al,
  output logic bh,
  output logic bl,
  output logic busy
);

  localparam logic [CntW-1:0] DtLoad = CntW'(DEAD_TIME);

`ifdef HBRIDGE_BRAKE_EN
  localparam logic BrakeEn = 1'b1;
`else
  localparam logic BrakeEn = 1'b0;
`endif

  state_e state_q, state_d;
  logic   dir_q, dir_d;
  gates_t gates_q, gates_d;
  logic   busy_q, busy_d;
  logic   tmr_load;
  logic   tmr_expire;
  logic   brake_req;

  assign brake_req = brake & BrakeEn;

  dt_timer u_dt_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (DtLoad),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    tmr_load = 1'b0;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          dir_d    = dir;
          tmr_load = 1'b1;
          state_d  = StDtAll;
        end
        StDtAll: begin
          if (tmr_expire) begin
`ifdef HBRIDGE_BRAKE_EN
            state_d = brake ? StBrake : StLo;
`else
            state_d = StLo;
`endif
          end
        end
        StDtLeg: begin
          if (brake_req || (dir != dir_q)) begin
            dir_d    = dir;
            tmr_load = 1'b1;
            state_d  = StDtAll;
          end else if (tmr_expire) begin
            state_d = PWM_sig ? StHi : StLo;
          end
        end
        StLo: begin
          // Low sides are already on, so braking needs no dead time from here.
          if (brake_req) begin
`ifdef HBRIDGE_BRAKE_EN
            state_d = StBrake;
`endif
          end else if (dir != dir_q) begin
            dir_d    = dir;
            tmr_load = 1'b1;
            state_d  = StDtAll;
          end else if (PWM_sig) begin
            tmr_load = 1'b1;
            state_d  = StDtLeg;
          end
        end
        StHi: begin
          if (brake_req || (dir != dir_q)) begin
            dir_d    = dir;
            tmr_load = 1'b1;
            state_d  = StDtAll;
          end else if (!PWM_sig) begin
            tmr_load = 1'b1;
            state_d  = StDtLeg;
          end
        end
`ifdef HBRIDGE_BRAKE_EN
        StBrake: begin
          if (!brake) begin
            dir_d   = dir;
            state_d = StLo;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
    gates_d = gate_decode(state_d, dir_d);
    busy_d  = (state_d == StDtAll) || (state_d == StDtLeg);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      gates_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      gates_q <= gates_d;
      busy_q  <= busy_d;
    end
  end

  assign ah   = gates_q.ah;
  assign al   = gates_q.al;
  assign bh   = gates_q.bh;
  assign bl   = gates_q.bl;
  assign busy = busy_q;

endmodule
